pipeline_hazard_ctrl: RTL

//  Central stall/flush sequencer for the 5-stage pipeline. Watches ID source regs, EX load/redirect/trap

---
 rtl/pipeline_hazard_ctrl.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline. Control outputs are combinational from the FSM state
// and the current hazard inputs, so negedge pipeline registers see them in the same cycle.
module pipeline_hazard_ctrl #(
    parameter int TRAP_DRAIN = 2,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs1addr,
    input  logic [4:0]       id_rs2addr,
    input  logic             id_rs1_use,
    input  logic             id_rs2_use,
    input  logic [4:0]       ex_rwaddr,
    input  logic             ex_memReadWen,
    input  logic             ex_redirect,
    input  logic             ex_trap,
    input  logic             ex_busy,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_hold,
    output logic             if_id_bubble,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             id_ex_flush,
    output logic             ex_mem_bubble,
    output logic             ex_mem_flush,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [1:0] ST_RUN      = 2'b00;
    localparam logic [1:0] ST_MEM_WAIT = 2'b01;
    localparam logic [1:0] ST_DRAIN    = 2'b10;

    // Control vector order: {pc_hold, if_id_bubble, if_id_flush, id_ex_bubble, id_ex_flush,
    //                        ex_mem_bubble, ex_mem_flush}
    localparam logic [6:0] CTL_NONE  = 7'b000_0000;
    localparam logic [6:0] CTL_HOLD  = 7'b110_1010;
    localparam logic [6:0] CTL_FLUSH = 7'b001_0100;
    localparam logic [6:0] CTL_BUSY  = 7'b110_1001;
    localparam logic [6:0] CTL_LDUSE = 7'b110_0100;

    localparam int              DRAIN_W    = (TRAP_DRAIN > 2) ? $clog2(TRAP_DRAIN) : 1;
    localparam logic [DRAIN_W-1:0] DRAIN_INIT = DRAIN_W'(TRAP_DRAIN - 1);
    localparam logic [DRAIN_W-1:0] DRAIN_ONE  = DRAIN_W'(1);
    localparam logic [DRAIN_W-1:0] DRAIN_ZERO = '0;

    logic [1:0]         state_reg;
    logic [1:0]         state_next;
    logic [DRAIN_W-1:0] drain_reg;
    logic [DRAIN_W-1:0] drain_next;
    logic [CNT_W-1:0]   stall_cnt_reg;
    logic [CNT_W-1:0]   flush_cnt_reg;

    logic       rs1_hit;
    logic       rs2_hit;
    logic       load_use;
    logic       mem_stall;
    logic [6:0] ev_ctl;
    logic [1:0] ev_state;
    logic [DRAIN_W-1:0] ev_drain;
    logic [6:0] ctl;

    assign rs1_hit   = id_rs1_use && (id_rs1addr == ex_rwaddr);
    assign rs2_hit   = id_rs2_use && (id_rs2addr == ex_rwaddr);
    assign load_use  = ex_memReadWen && (ex_rwaddr != 5'd0) && (rs1_hit || rs2_hit);
    assign mem_stall = mem_req && !mem_ready;

    // Priority cases below the memory stall; shared by RUN and the release cycle of MEM_WAIT so a
    // trap or redirect parked in EX during a memory wait is acted on as soon as memory completes.
    always_comb begin
        ev_ctl   = CTL_NONE;
        ev_state = ST_RUN;
        ev_drain = DRAIN_ZERO;
        if (ex_trap) begin
            ev_ctl = CTL_FLUSH;
            if (TRAP_DRAIN > 1) begin
                ev_state = ST_DRAIN;
                ev_drain = DRAIN_INIT;
            end
        end else if (ex_redirect) begin
            ev_ctl = CTL_FLUSH;
        end else if (ex_busy) begin
            ev_ctl = CTL_BUSY;
        end else if (load_use) begin
            ev_ctl = CTL_LDUSE;
        end
    end

    always_comb begin
        ctl        = CTL_NONE;
        state_next = state_reg;
        drain_next = drain_reg;
        case (state_reg)
            ST_RUN: begin
                if (mem_stall) begin
                    ctl        = CTL_HOLD;
                    state_next = ST_MEM_WAIT;
                end else begin
                    ctl        = ev_ctl;
                    state_next = ev_state;
                    drain_next = ev_drain;
                end
            end
            ST_MEM_WAIT: begin
                if (!mem_ready) begin
                    ctl = CTL_HOLD;
                end else begin
                    ctl        = ev_ctl;
                    state_next = ev_state;
                    drain_next = ev_drain;
                end
            end
            ST_DRAIN: begin
                // A memory stall freezes the drain; a new trap here is ignored since ID/EX is being cleared.
                if (mem_stall) begin
                    ctl = CTL_HOLD;
                end else begin
                    ctl = CTL_FLUSH;
                    if (drain_reg <= DRAIN_ONE) begin
                        state_next = ST_RUN;
                        drain_next = DRAIN_ZERO;
                    end else begin
                        drain_next = drain_reg - DRAIN_ONE;
                    end
                end
            end
            default: begin
                state_next = ST_RUN;
                drain_next = DRAIN_ZERO;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= ST_RUN;
            drain_reg     <= DRAIN_ZERO;
            stall_cnt_reg <= '0;
            flush_cnt_reg <= '0;
        end else begin
            state_reg <= state_next;
            drain_reg <= drain_next;
            if (ctl[6]) begin
                stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
            end
            if (ctl[2]) begin
                flush_cnt_reg <= flush_cnt_reg + CNT_W'(1);
            end
        end
    end

    assign pc_hold       = ctl[6];
    assign if_id_bubble  = ctl[5];
    assign if_id_flush   = ctl[4];
    assign id_ex_bubble  = ctl[3];
    assign id_ex_flush   = ctl[2];
    assign ex_mem_bubble = ctl[1];
    assign ex_mem_flush  = ctl[0];
    assign state_o       = state_reg;
    assign stall_cnt     = stall_cnt_reg;
    assign flush_cnt     = flush_cnt_reg;

endmodule
